login_session_ctrl: RTL and testbench

Session controller in front of the UART credential checker. It forwards received bytes from the UART RX into the checker one attempt at a time and enforces inter-byte and result timeouts. It counts consecutive failed attempts and locks the interface out for a fixed period after too many failures. It also holds an authenticated session open until logout.

---
 rtl/login_session_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_login_session_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/login_session_ctrl.sv
// Session controller between the UART RX and the credential checker: forwards one login
// attempt at a time, times out stalled attempts, counts failures and enforces lockout.
module login_session_ctrl #(
    parameter int unsigned FRAME_LEN      = 8,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned BYTE_TIMEOUT   = 500,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_data_valid_i,
    input  logic                          chk_success_i,
    input  logic                          chk_fail_i,
    input  logic                          logout_i,
    output logic [7:0]                    chk_data_o,
    output logic                          chk_valid_o,
    output logic                          chk_rst_o,
    output logic                          session_active_o,
    output logic                          locked_o,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count_o,
    output logic                          timeout_evt_o,
    output logic                          lockout_evt_o
);

    localparam int unsigned FailW = $clog2(MAX_FAIL + 1);
    localparam int unsigned CntW  = $clog2(FRAME_LEN + 1);
    localparam int unsigned TmrW  = $clog2(BYTE_TIMEOUT);
    localparam int unsigned LckW  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCollect = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StSession = 3'd3;
    localparam logic [2:0] StLocked  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TmrW-1:0] idle_tmr_q, idle_tmr_d;
    logic [LckW-1:0] lock_tmr_q, lock_tmr_d;
    logic [FailW-1:0] fail_cnt_q, fail_cnt_d;
    logic [7:0]      chk_data_q, chk_data_d;
    logic            chk_valid_q, chk_valid_d;
    logic            chk_rst_q, chk_rst_d;
    logic            timeout_q, timeout_d;
    logic            lockout_q, lockout_d;

    logic             fail_hit;
    logic             timeout_hit;
    logic             idle_expired;
    logic [CntW-1:0]  byte_cnt_inc;
    logic [FailW-1:0] fail_cnt_inc;

    assign idle_expired = (idle_tmr_q == TmrW'(BYTE_TIMEOUT - 1));
    assign byte_cnt_inc = byte_cnt_q + CntW'(1);
    assign fail_cnt_inc = (fail_cnt_q < FailW'(MAX_FAIL)) ? fail_cnt_q + FailW'(1) : fail_cnt_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        idle_tmr_d  = idle_tmr_q;
        lock_tmr_d  = lock_tmr_q;
        fail_cnt_d  = fail_cnt_q;
        chk_data_d  = chk_data_q;
        chk_valid_d = 1'b0;
        chk_rst_d   = 1'b0;
        timeout_d   = 1'b0;
        lockout_d   = 1'b0;
        fail_hit    = 1'b0;
        timeout_hit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_data_valid_i) begin
                    chk_valid_d = 1'b1;
                    chk_data_d  = rx_data_i;
                    byte_cnt_d  = CntW'(1);
                    idle_tmr_d  = '0;
                    state_d     = (FRAME_LEN <= 1) ? StWait : StCollect;
                end
            end
            StCollect: begin
                // A byte landing in the expiry cycle takes priority over the timeout.
                if (rx_data_valid_i) begin
                    chk_valid_d = 1'b1;
                    chk_data_d  = rx_data_i;
                    byte_cnt_d  = byte_cnt_inc;
                    idle_tmr_d  = '0;
                    if (byte_cnt_inc == CntW'(FRAME_LEN)) begin
                        state_d = StWait;
                    end
                end else if (idle_expired) begin
                    timeout_hit = 1'b1;
                end else begin
                    idle_tmr_d = idle_tmr_q + TmrW'(1);
                end
            end
            StWait: begin
                if (chk_fail_i) begin
                    fail_hit = 1'b1;
                end else if (chk_success_i) begin
                    state_d    = StSession;
                    fail_cnt_d = '0;
                end else if (idle_expired) begin
                    timeout_hit = 1'b1;
                end else begin
                    idle_tmr_d = idle_tmr_q + TmrW'(1);
                end
            end
            StSession: begin
                if (logout_i) begin
                    state_d = StIdle;
                end
            end
            StLocked: begin
                if (lock_tmr_q == LckW'(LOCKOUT_CYCLES - 1)) begin
                    state_d    = StIdle;
                    fail_cnt_d = '0;
                    lock_tmr_d = '0;
                end else begin
                    lock_tmr_d = lock_tmr_q + LckW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout_hit) begin
            chk_rst_d = 1'b1;
            timeout_d = 1'b1;
        end

        // Timeouts and checker rejections share the same failure bookkeeping.
        if (fail_hit || timeout_hit) begin
            fail_cnt_d = fail_cnt_inc;
            byte_cnt_d = '0;
            idle_tmr_d = '0;
            if (fail_cnt_inc == FailW'(MAX_FAIL)) begin
                state_d    = StLocked;
                lockout_d  = 1'b1;
                lock_tmr_d = '0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            idle_tmr_q  <= '0;
            lock_tmr_q  <= '0;
            fail_cnt_q  <= '0;
            chk_data_q  <= '0;
            chk_valid_q <= 1'b0;
            chk_rst_q   <= 1'b0;
            timeout_q   <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_tmr_q  <= idle_tmr_d;
            lock_tmr_q  <= lock_tmr_d;
            fail_cnt_q  <= fail_cnt_d;
            chk_data_q  <= chk_data_d;
            chk_valid_q <= chk_valid_d;
            chk_rst_q   <= chk_rst_d;
            timeout_q   <= timeout_d;
            lockout_q   <= lockout_d;
        end
    end

    assign chk_data_o       = chk_data_q;
    assign chk_valid_o      = chk_valid_q;
    assign chk_rst_o        = chk_rst_q;
    assign timeout_evt_o    = timeout_q;
    assign lockout_evt_o    = lockout_q;
    assign fail_count_o     = fail_cnt_q;
    assign session_active_o = (state_q == StSession);
    assign locked_o         = (state_q == StLocked);

endmodule

// File: tb/tb_login_session_ctrl.sv
// Bench for login_session_ctrl: directed scenarios plus random traffic, all checked against a
// timestamp-based behavioural model of the session rules.
module tb_login_session_ctrl;

    localparam int FRAME_LEN      = 8;
    localparam int MAX_FAIL       = 3;
    localparam int BYTE_TIMEOUT   = 500;
    localparam int LOCKOUT_CYCLES = 1000;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_WAIT    = 2;
    localparam int M_SESSION = 3;
    localparam int M_LOCKED  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic       chk_success = 1'b0;
    logic       chk_fail = 1'b0;
    logic       logout = 1'b0;
    logic [7:0] chk_data;
    logic       chk_valid, chk_rst, session_active, locked, timeout_evt, lockout_evt;
    logic [1:0] fail_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: mode, bytes in attempt, cycle of last activity, lockout cycles left.
    int         m_mode, m_got, m_last, m_lock_left, m_fails, m_cyc;
    logic       m_cv, m_rst, m_tmo, m_le;
    logic [7:0] m_cd;

    login_session_ctrl #(
        .FRAME_LEN      (FRAME_LEN),
        .MAX_FAIL       (MAX_FAIL),
        .BYTE_TIMEOUT   (BYTE_TIMEOUT),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_data_i        (rx_data),
        .rx_data_valid_i  (rx_data_valid),
        .chk_success_i    (chk_success),
        .chk_fail_i       (chk_fail),
        .logout_i         (logout),
        .chk_data_o       (chk_data),
        .chk_valid_o      (chk_valid),
        .chk_rst_o        (chk_rst),
        .session_active_o (session_active),
        .locked_o         (locked),
        .fail_count_o     (fail_count),
        .timeout_evt_o    (timeout_evt),
        .lockout_evt_o    (lockout_evt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_vec();
        return {chk_valid, chk_rst, timeout_evt, lockout_evt, session_active, locked,
                fail_count, chk_data};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_cv, m_rst, m_tmo, m_le, m_mode == M_SESSION, m_mode == M_LOCKED,
                2'(m_fails), m_cd};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_got = 0; m_last = 0; m_lock_left = 0; m_fails = 0; m_cyc = 0;
        m_cv = 0; m_rst = 0; m_tmo = 0; m_le = 0; m_cd = 8'h00;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic s,
                                       input logic f, input logic l);
        bit failed = 0;
        bit tmo    = 0;
        m_cyc++;
        m_cv = 0; m_rst = 0; m_tmo = 0; m_le = 0;
        case (m_mode)
            M_IDLE: if (v) begin
                m_cv = 1; m_cd = d; m_got = 1; m_last = m_cyc;
                m_mode = (m_got >= FRAME_LEN) ? M_WAIT : M_COLLECT;
            end
            M_COLLECT: begin
                if (v) begin
                    m_cv = 1; m_cd = d; m_got++; m_last = m_cyc;
                    if (m_got == FRAME_LEN) m_mode = M_WAIT;
                end else if (m_cyc - m_last >= BYTE_TIMEOUT) tmo = 1;
            end
            M_WAIT: begin
                if (f) failed = 1;
                else if (s) begin m_mode = M_SESSION; m_fails = 0; end
                else if (m_cyc - m_last >= BYTE_TIMEOUT) tmo = 1;
            end
            M_SESSION: if (l) m_mode = M_IDLE;
            M_LOCKED: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_fails = 0; m_mode = M_IDLE; end
            end
            default: m_mode = M_IDLE;
        endcase
        if (tmo) begin m_rst = 1; m_tmo = 1; failed = 1; end
        if (failed) begin
            if (m_fails < MAX_FAIL) m_fails++;
            if (m_fails == MAX_FAIL) begin
                m_mode = M_LOCKED; m_le = 1; m_lock_left = LOCKOUT_CYCLES;
            end else m_mode = M_IDLE;
        end
    endfunction

    // Drives one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic f,
                        input logic l);
        rx_data_valid = v; rx_data = d; chk_success = s; chk_fail = f; logout = l;
        @(posedge clk);
        model_step(v, d, s, f, l);
        #1;
        rx_data_valid = 1'b0; chk_success = 1'b0; chk_fail = 1'b0; logout = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_data_valid = 1'b0; chk_success = 1'b0; chk_fail = 1'b0; logout = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_data_valid = 1'b1; rx_data = 8'($urandom); chk_success = 1'b1; logout = 1'b1;
            @(posedge clk);
            #1;
            n_assert++;
            if (dut_vec() !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want 0000", dut_vec());
            end
        end
        do_reset();
        n_assert++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_login();
        string pw = "userpass";
        int    ncv = 0;
        do_reset();
        for (int t = 0; t <= 73; t++) begin
            step((t % 10 == 0) && (t <= 70), pw[t / 10], t == 73, 1'b0, 1'b0);
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL login cyc %0d: got %h want %h", m_cyc, dut_vec(), exp_vec());
            end
            if (chk_valid) ncv++;
        end
        n_assert++;
        if (ncv !== FRAME_LEN || session_active !== 1'b1 || fail_count !== 2'd0) begin
            n_fail++;
            $display("FAIL login_result: pulses %0d sess %b fails %0d want %0d 1 0",
                     ncv, session_active, fail_count, FRAME_LEN);
        end
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_assert++;
        if (session_active !== 1'b0 || chk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL logout: sess %b cv %b want 0 0", session_active, chk_valid);
        end
    endtask

    task automatic test_lockout();
        int lock_cyc = 0, cv_in_lock = 0, le_cnt = 0;
        do_reset();
        for (int a = 0; a < MAX_FAIL; a++) begin
            for (int b = 0; b < FRAME_LEN; b++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 20)) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            n_assert++;
            if (fail_count !== 2'(a + 1) || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lock_failcnt %0d: got %h want %h", a, dut_vec(), exp_vec());
            end
        end
        lock_cyc = locked ? 1 : 0;
        le_cnt   = lockout_evt ? 1 : 0;
        for (int i = 0; i < 2 * LOCKOUT_CYCLES; i++) begin
            step(1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'($urandom));
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lock cyc %0d: got %h want %h", m_cyc, dut_vec(), exp_vec());
            end
            if (lockout_evt) le_cnt++;
            if (chk_valid) cv_in_lock++;
            if (!locked) break;
            lock_cyc++;
        end
        n_assert++;
        if (lock_cyc !== LOCKOUT_CYCLES || le_cnt !== 1 || cv_in_lock !== 0 ||
            fail_count !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_summary: len %0d evt %0d cv %0d fails %0d want %0d 1 0 0",
                     lock_cyc, le_cnt, cv_in_lock, fail_count, LOCKOUT_CYCLES);
        end
    endtask

    task automatic test_timeout();
        int gap = -1;
        do_reset();
        for (int b = 0; b < 4; b++) step(1'b1, 8'(8'h30 + b), 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= BYTE_TIMEOUT + 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got %h want %h", m_cyc, dut_vec(), exp_vec());
            end
            if (chk_rst && gap < 0) gap = i;
        end
        n_assert++;
        if (gap !== BYTE_TIMEOUT || fail_count !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_gap: gap %0d fails %0d want %0d 1", gap, fail_count,
                     BYTE_TIMEOUT);
        end
        for (int b = 0; b < FRAME_LEN; b++) begin
            step(1'b1, 8'(8'hA0 + b), 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_restart %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_assert++;
        if (session_active !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_relogin: sess %b want 1", session_active);
        end
    endtask

    task automatic test_expiry_wins();
        int rst_seen = 0;
        do_reset();
        for (int b = 0; b < 3; b++) step(1'b1, 8'(8'h61 + b), 1'b0, 1'b0, 1'b0);
        repeat (BYTE_TIMEOUT - 1) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (chk_rst) rst_seen++;
        end
        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (chk_valid !== 1'b1 || chk_rst !== 1'b0 || chk_data !== 8'h7E || rst_seen != 0) begin
            n_fail++;
            $display("FAIL expiry_byte: cv %b rst %b data %h early %0d want 1 0 7e 0",
                     chk_valid, chk_rst, chk_data, rst_seen);
        end
        for (int b = 4; b < FRAME_LEN; b++) step(1'b1, 8'(b), 1'b0, 1'b0, 1'b0);
        repeat (BYTE_TIMEOUT - 1) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_assert++;
        if (session_active !== 1'b1 || timeout_evt !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL expiry_result: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_both_results();
        do_reset();
        for (int b = 0; b < FRAME_LEN; b++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        n_assert++;
        if (session_active !== 1'b0 || fail_count !== 2'd1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL both_results: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int b = 0; b < 3; b++) step(1'b1, 8'(8'h40 + b), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_assert++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_collect: got %h want %h", dut_vec(), exp_vec());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int b = 0; b < FRAME_LEN; b++) begin
            step(1'b1, 8'(8'hC0 + b), 1'b0, 1'b0, 1'b0);
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_refill %0d: got %h want %h", b, dut_vec(), exp_vec());
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_assert++;
        if (session_active !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_relogin: sess %b want 1", session_active);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int a = 0; a < MAX_FAIL; a++) begin
            step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
            repeat (BYTE_TIMEOUT) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        repeat (100) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (locked !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_prelock: got %h want %h", dut_vec(), exp_vec());
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_assert++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_locked: got %h want %h", dut_vec(), exp_vec());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        n_assert++;
        if (chk_valid !== 1'b1 || chk_data !== 8'h99 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_firstbyte: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            int rate = (seg % 4 == 0) ? 0 : (seg % 4 == 1) ? 2 : (seg % 4 == 2) ? 30 : 90;
            int len  = $urandom_range(50, 700);
            for (int i = 0; i < len; i++) begin
                step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 99) < 4,
                     $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
                n_assert++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got %h want %h", m_cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_login();
        test_lockout();
        test_timeout();
        test_expiry_wins();
        test_both_results();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
